// File: rtl/afifo_pkg.sv
// Shared types and Gray-code helpers for the 4-entry async FIFO.
// Optional read-level output is enabled with AFIFO_RD_LEVEL_EN.
package afifo_pkg;

  localparam int AW = 2;
  localparam int DW = 32;

  typedef logic [AW:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/afifo_sync2.sv
// Two-flop synchroniser, synchronous active-high reset.
// Shared by the read- and write-side FIFO controllers.
module afifo_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/afifo_rd_ctrl.sv
// Read-side controller of the async FIFO with a 2-entry skid buffer.
// Define AFIFO_RD_LEVEL_EN to add the registered rd_level output.
module afifo_rd_ctrl
  import afifo_pkg::*;
#(
  parameter int AFIFODW = DW,
  parameter int AFIFOAW = AW
) (
`ifdef AFIFO_RD_LEVEL_EN
  output logic [AFIFOAW:0]   rd_level,
`endif
  input  logic               clk,
  input  logic               rst,
  input  logic [AFIFOAW:0]   wptr_gray,
  output logic [AFIFOAW:0]   rptr_gray,
  output logic [AFIFOAW-1:0] ram_radr,
  input  logic [AFIFODW-1:0] ram_rdata,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [AFIFODW-1:0] rd_data,
  output logic               empty
);

  logic [AFIFOAW:0]   wsync_gray;
  logic [AFIFOAW:0]   wsync_bin;
  logic [AFIFOAW:0]   rptr_bin;
  logic [AFIFOAW:0]   rptr_nxt;
  logic               inflight;
  logic [1:0]         buf_cnt;
  logic [AFIFODW-1:0] skid [2];
  logic               head;
  logic               tail;
  logic               pop;
  logic               issue;
  logic               empty_int;
  logic [2:0]         occ;

  afifo_sync2 #(
    .W (AFIFOAW + 1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (wptr_gray),
    .q   (wsync_gray)
  );

  assign wsync_bin = gray2bin(wsync_gray);
  assign empty_int = (rptr_bin == wsync_bin);
  assign empty     = empty_int;

  assign rd_valid = (buf_cnt != 2'd0);
  assign rd_data  = skid[head];
  assign pop      = rd_valid && rd_ready;

  // Slots committed after this edge: buffered plus in flight, minus pop.
  assign occ   = {1'b0, buf_cnt} + {2'b0, inflight} - {2'b0, pop};
  assign issue = !empty_int && (occ < 3'd2);

  assign rptr_nxt = issue ? rptr_bin + (AFIFOAW+1)'(1) : rptr_bin;
  assign ram_radr = rptr_bin[AFIFOAW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_bin  <= '0;
      rptr_gray <= '0;
      inflight  <= 1'b0;
      buf_cnt   <= 2'd0;
      head      <= 1'b0;
      tail      <= 1'b0;
      skid[0]   <= '0;
      skid[1]   <= '0;
    end else begin
      rptr_bin  <= rptr_nxt;
      rptr_gray <= bin2gray(rptr_nxt);
      inflight  <= issue;
      if (inflight) begin
        skid[tail] <= ram_rdata;
        tail       <= ~tail;
      end
      if (pop) begin
        head <= ~head;
      end
      case ({inflight, pop})
        2'b10:   buf_cnt <= buf_cnt + 2'd1;
        2'b01:   buf_cnt <= buf_cnt - 2'd1;
        default: buf_cnt <= buf_cnt;
      endcase
    end
  end

`ifdef AFIFO_RD_LEVEL_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_level <= '0;
    end else begin
      rd_level <= wsync_bin - rptr_bin;
    end
  end
`endif

endmodule
